// File: rtl/bp_reg_initiator.sv
// Host-side initiator for the bytepipe register protocol: turns one register request into
// command/data bytes on the outbound pipe and returns response bytes on a read-data stream.
module bp_reg_initiator #(
    parameter int unsigned TIMEOUT     = 0,
    parameter bit          FWD_WR_RESP = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cg,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_wr,
    input  logic [6:0] i_req_addr,
    input  logic [7:0] i_req_len,
    input  logic [7:0] i_wdata,
    input  logic       i_wdata_valid,
    output logic       o_wdata_ready,
    output logic [7:0] o_rdata,
    output logic       o_rdata_valid,
    output logic       o_rdata_last,
    input  logic       i_rdata_ready,
    output logic [7:0] o_bp_data,
    output logic       o_bp_valid,
    input  logic       i_bp_ready,
    input  logic [7:0] i_bp_data,
    input  logic       i_bp_valid,
    output logic       o_bp_ready,
    output logic       o_timeout
);

    typedef enum logic [2:0] {
        StIdle,
        StSetupCmd,
        StSetupLen,
        StSetupRsp,
        StCmd,
        StWdata,
        StRsp
    } state_t;

    state_t      stateQ;
    logic        wrQ;
    logic [6:0]  addrQ;
    logic [7:0]  lenQ;
    logic [7:0]  beatQ;
    logic [31:0] toQ;
    logic        timeoutQ;

    logic fwd;
    logic outAcc;
    logic inAcc;
    logic toHit;

    assign fwd       = !wrQ || FWD_WR_RESP;
    assign outAcc    = o_bp_valid && i_bp_ready;
    assign inAcc     = o_bp_ready && i_bp_valid;
    assign toHit     = (TIMEOUT != 0) && ((toQ + 32'd1) == TIMEOUT);
    assign o_timeout = timeoutQ;

    always_comb begin
        o_req_ready   = 1'b0;
        o_bp_data     = 8'h00;
        o_bp_valid    = 1'b0;
        o_bp_ready    = 1'b0;
        o_wdata_ready = 1'b0;
        o_rdata       = i_bp_data;
        o_rdata_valid = 1'b0;
        o_rdata_last  = 1'b0;
        unique case (stateQ)
            StIdle:     o_req_ready = 1'b1;
            StSetupCmd: begin
                o_bp_data  = 8'h80;
                o_bp_valid = 1'b1;
            end
            StSetupLen: begin
                o_bp_data  = lenQ;
                o_bp_valid = 1'b1;
            end
            StSetupRsp: o_bp_ready = 1'b1;
            StCmd: begin
                o_bp_data  = {wrQ, addrQ};
                o_bp_valid = 1'b1;
            end
            StWdata: begin
                o_bp_data     = i_wdata;
                o_bp_valid    = i_wdata_valid;
                o_wdata_ready = i_bp_ready;
            end
            StRsp: begin
                o_bp_ready    = fwd ? i_rdata_ready : 1'b1;
                o_rdata_valid = i_bp_valid && fwd;
                o_rdata_last  = (beatQ == 8'd0);
            end
            default: o_req_ready = 1'b0;
        endcase
        // With the clock gated nothing may complete, so no handshake is offered.
        if (!i_cg) begin
            o_req_ready   = 1'b0;
            o_bp_valid    = 1'b0;
            o_bp_ready    = 1'b0;
            o_wdata_ready = 1'b0;
            o_rdata_valid = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stateQ   <= StIdle;
            wrQ      <= 1'b0;
            addrQ    <= 7'd0;
            lenQ     <= 8'd0;
            beatQ    <= 8'd0;
            toQ      <= 32'd0;
            timeoutQ <= 1'b0;
        end else if (i_cg) begin
            timeoutQ <= 1'b0;
            toQ      <= 32'd0;
            unique case (stateQ)
                StIdle: if (i_req_valid) begin
                    wrQ    <= i_req_wr;
                    addrQ  <= i_req_addr;
                    lenQ   <= (i_req_addr == 7'd0) ? 8'd0 : i_req_len;
                    stateQ <= (i_req_addr != 7'd0 && i_req_len != 8'd0) ? StSetupCmd : StCmd;
                end
                StSetupCmd: if (outAcc) stateQ <= StSetupLen;
                StSetupLen: if (outAcc) stateQ <= StSetupRsp;
                StSetupRsp: if (inAcc) stateQ <= StCmd;
                StCmd: if (outAcc) begin
                    beatQ  <= lenQ;
                    stateQ <= wrQ ? StWdata : StRsp;
                end
                StWdata: if (outAcc) begin
                    if (beatQ == 8'd0) stateQ <= StRsp;
                    else beatQ <= beatQ - 8'd1;
                end
                StRsp: if (inAcc) begin
                    if (beatQ == 8'd0) stateQ <= StIdle;
                    else beatQ <= beatQ - 8'd1;
                end
                default: stateQ <= StIdle;
            endcase
            // Waiting on the responder: count idle cycles; overrides the case above on abort.
            if ((stateQ == StSetupRsp || stateQ == StRsp) && !inAcc) begin
                if (toHit) begin
                    stateQ   <= StIdle;
                    timeoutQ <= 1'b1;
                end else begin
                    toQ <= toQ + 32'd1;
                end
            end
        end
    end

endmodule
